// File: rtl/dpram_pkg.sv
// dpram_pkg
// Shared definitions for the byte-enable dual-port RAM with clear sweep.
//   state_t    : sweep sequencer states (ST_CLEAR, ST_RUN)
//   byteCount  : number of byte lanes in a word of the given width
//   byteMerge  : one byte lane of a masked write (also feeds the bypass path)
// Optional build macro used by the RAM: DPRAM_BYPASS_EN (write-first reads).
package dpram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int byteCount(input int dataW);
    return dataW / 8;
  endfunction

  // Returns the new lane when its enable is set, otherwise keeps the old lane.
  function automatic logic [7:0] byteMerge(input logic [7:0] oldByte,
                                           input logic [7:0] newByte,
                                           input logic       enable);
    return enable ? newByte : oldByte;
  endfunction

endpackage

// File: rtl/dpram_bwe_clr_if.sv
// dpram_bwe_clr_if
// Bundles the RAM's request/response signals.
//   clr / busy              : sweep restart request and sweep-in-progress flag
//   we, waddr, wdata, wbe   : write port with per-byte enables
//   re, raddr, rdata, rvalid: read port, registered data plus valid strobe
// Modports: master drives requests, slave (the RAM) returns busy/rdata/rvalid.
interface dpram_bwe_clr_if
  import dpram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  localparam int NBYTES = byteCount(DATA_W);

  logic              clr;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [NBYTES-1:0] wbe;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output clr, we, waddr, wdata, wbe, re, raddr,
    input  busy, rdata, rvalid
  );

  modport slave (
    input  clr, we, waddr, wdata, wbe, re, raddr,
    output busy, rdata, rvalid
  );

endinterface

// File: rtl/dpram_clr_seq.sv
// dpram_clr_seq
// Zeroing sweep sequencer: after reset or a clear request it walks every
// address once, then hands the RAM over to normal traffic.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_clr         : restart the sweep from address 0
//   o_busy        : high while sweeping (decoded from the state register)
//   o_sweepAddr   : address being zeroed this cycle
//   o_sweepWe     : zero-write strobe for o_sweepAddr
module dpram_clr_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sweepAddr,
  output logic              o_sweepWe
);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_nextCnt;

  // State and sweep counter; reset lands in CLEAR at address 0 so busy is
  // asserted the moment reset is applied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Next state: the sweep ends after the all-ones address is written; a
  // clear request overrides everything and restarts from 0.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    o_sweepWe   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        o_sweepWe = 1'b1;
        if (r_cnt == '1) begin
          w_nextState = ST_RUN;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_nextState = ST_RUN;
      end
      default: begin
        w_nextState = ST_CLEAR;
        w_nextCnt   = '0;
      end
    endcase
    if (i_clr) begin
      w_nextState = ST_CLEAR;
      w_nextCnt   = '0;
    end
  end

  assign o_busy      = (r_state == ST_CLEAR);
  assign o_sweepAddr = r_cnt;

endmodule

// File: rtl/dpram_bwe_clr.sv
// dpram_bwe_clr
// Parametrised dual-port RAM: one synchronous byte-enabled write port, one
// registered read port with valid strobe, and a built-in zeroing sweep.
//   clk      : clock, all logic on the rising edge
//   reset_n  : asynchronous active-low reset (restarts the sweep)
//   bus      : dpram_bwe_clr_if slave (clr/busy, write port, read port)
// Build macro DPRAM_BYPASS_EN: when defined, a same-cycle read of the write
// address returns the merged new word (write-first); otherwise the old word
// (read-first, maps straight onto vendor block RAM).
module dpram_bwe_clr
  import dpram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  dpram_bwe_clr_if.slave bus
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = byteCount(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic              w_busy;
  logic [ADDR_W-1:0] w_sweepAddr;
  logic              w_sweepWe;
  logic              w_runWe;
  logic              w_runRe;
  logic [DATA_W-1:0] w_oldWord;
  logic [DATA_W-1:0] w_merged;

  dpram_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clrSeq (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (bus.clr),
    .o_busy     (w_busy),
    .o_sweepAddr(w_sweepAddr),
    .o_sweepWe  (w_sweepWe)
  );

  // Port traffic is only honoured in RUN and is dropped in a clear cycle.
  assign w_runWe = bus.we & ~w_busy & ~bus.clr;
  assign w_runRe = bus.re & ~w_busy & ~bus.clr;

  // Merged word for a masked write: enabled lanes from wdata, the rest from
  // the current contents of the write address.
  assign w_oldWord = r_mem[bus.waddr];
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w_merged[8*i +: 8] = byteMerge(w_oldWord[8*i +: 8], bus.wdata[8*i +: 8], bus.wbe[i]);
    end
  end

  // Memory array has no reset; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (w_sweepWe) begin
      r_mem[w_sweepAddr] <= '0;
    end else if (w_runWe) begin
      r_mem[bus.waddr] <= w_merged;
    end
  end

  // Registered read port; rdata holds whenever no read is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_runRe;
      if (w_runRe) begin
`ifdef DPRAM_BYPASS_EN
        if (w_runWe && (bus.waddr == bus.raddr)) begin
          r_rdata <= w_merged;
        end else begin
          r_rdata <= r_mem[bus.raddr];
        end
`else
        r_rdata <= r_mem[bus.raddr];
`endif
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_dpram_bwe_clr.sv
// tb_dpram_bwe_clr
// Directed bench for dpram_bwe_clr (DATA_W=32, ADDR_W=5) with hand-computed
// expected values. Honours DPRAM_BYPASS_EN for the read-during-write case.
module tb_dpram_bwe_clr;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  logic [31:0] expSameCycle;

  dpram_bwe_clr_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  dpram_bwe_clr #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case something never finishes
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests, then advance past the sampling edge
  task automatic applyStimulus(input logic iWe, input logic [4:0] iWaddr,
                               input logic [31:0] iWdata, input logic [3:0] iWbe,
                               input logic iRe, input logic [4:0] iRaddr,
                               input logic iClr);
    bus.we    = iWe;
    bus.waddr = iWaddr;
    bus.wdata = iWdata;
    bus.wbe   = iWbe;
    bus.re    = iRe;
    bus.raddr = iRaddr;
    bus.clr   = iClr;
    step();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic writeWord(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    applyStimulus(1'b1, a, d, be, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic readCheck(input string tag, input logic [4:0] a, input logic [31:0] exp);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, a, 1'b0);
    checkOutput({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
    checkOutput(tag, bus.rdata, exp);
  endtask

  // Count cycles with busy high (including the current one); optionally
  // attempt a write to addr 5 late in the sweep, after addr 5 was zeroed.
  task automatic measureBusy(input string tag, input bit lateWrite);
    int cnt;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (lateWrite && cnt == 20) begin
        applyStimulus(1'b1, 5'd5, 32'h12345678, 4'hF, 1'b1, 5'd5, 1'b0);
        checkOutput("busyReadDropped", {31'b0, bus.rvalid}, 32'd0);
      end else begin
        idle();
      end
    end
    checkOutput(tag, cnt, 32'd32);
  endtask

  function automatic logic [31:0] patt(input int a);
    logic [7:0] lo;
    lo = 8'h5A ^ 8'(a);
    return {16'hC0DE, 8'(a), lo};
  endfunction

  initial begin
`ifdef DPRAM_BYPASS_EN
    expSameCycle = 32'hCAFEF00D;
`else
    expSameCycle = 32'h00000000;
`endif
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wbe = '0;
    bus.re = 1'b0; bus.raddr = '0; bus.clr = 1'b0;

    // Reset state
    step();
    step();
    checkOutput("rstBusy",   {31'b0, bus.busy},   32'd1);
    checkOutput("rstRvalid", {31'b0, bus.rvalid}, 32'd0);
    checkOutput("rstRdata",  bus.rdata,           32'h0);
    reset_n = 1'b1;
    measureBusy("initSweepLen", 1'b0);

    // Every word reads zero, back-to-back
    for (int a = 0; a < 32; a++) begin
      readCheck("sweepZero", 5'(a), 32'h0);
    end
    idle();
    checkOutput("rvalidDrop", {31'b0, bus.rvalid}, 32'd0);

    // Byte-enable merge and wbe=0 no-op
    writeWord(5'd3, 32'hDEADBEEF, 4'hF);
    writeWord(5'd3, 32'h11223344, 4'h5);
    readCheck("bweMerge", 5'd3, 32'hDE22BE44);
    writeWord(5'd3, 32'h00000000, 4'h0);
    readCheck("bweNone", 5'd3, 32'hDE22BE44);

    // Read-during-write to same address, then the follow-up read
    applyStimulus(1'b1, 5'd7, 32'hCAFEF00D, 4'hF, 1'b1, 5'd7, 1'b0);
    checkOutput("rdwSame", bus.rdata, expSameCycle);
    readCheck("rdwNext", 5'd7, 32'hCAFEF00D);

    // Independent addresses in the same cycle
    applyStimulus(1'b1, 5'd8, 32'h0BADC0DE, 4'hF, 1'b1, 5'd3, 1'b0);
    checkOutput("indepRead", bus.rdata, 32'hDE22BE44);
    readCheck("indepWrite", 5'd8, 32'h0BADC0DE);

    // Burst of 8 reads with re held high
    for (int a = 0; a < 8; a++) begin
      writeWord(5'(a), patt(a), 4'hF);
    end
    for (int a = 0; a < 8; a++) begin
      readCheck("burst", 5'(a), patt(a));
    end
    idle();
    checkOutput("burstEnd", {31'b0, bus.rvalid}, 32'd0);

    // Clear request: traffic in the clr cycle and during the sweep is dropped
    writeWord(5'd31, 32'hFFFFFFFF, 4'hF);
    writeWord(5'd5, 32'h55555555, 4'hF);
    readCheck("preClr31", 5'd31, 32'hFFFFFFFF);
    applyStimulus(1'b1, 5'd6, 32'h66666666, 4'hF, 1'b1, 5'd31, 1'b1);
    checkOutput("clrBusy",   {31'b0, bus.busy},   32'd1);
    checkOutput("clrRvalid", {31'b0, bus.rvalid}, 32'd0);
    measureBusy("clrSweepLen", 1'b1);
    readCheck("postClr5", 5'd5, 32'h0);
    readCheck("postClr31", 5'd31, 32'h0);
    readCheck("postClr6", 5'd6, 32'h0);

    // Reset in the middle of a sweep
    writeWord(5'd9, 32'hA5A5A5A5, 4'hF);
    readCheck("preRst9", 5'd9, 32'hA5A5A5A5);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b1);
    repeat (10) idle();
    checkOutput("sweepHoldRdata", bus.rdata, 32'hA5A5A5A5);
    checkOutput("sweepBusy", {31'b0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstBusy",   {31'b0, bus.busy},   32'd1);
    checkOutput("midRstRvalid", {31'b0, bus.rvalid}, 32'd0);
    checkOutput("midRstRdata",  bus.rdata,           32'h0);
    #2;
    reset_n = 1'b1;
    measureBusy("rstSweepLen", 1'b0);
    readCheck("postRst9", 5'd9, 32'h0);
    readCheck("postRst8", 5'd8, 32'h0);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_bwe_clr.md
# dpram_bwe_clr

Parametrised dual-port RAM that succeeds the fixed 32x32 cache RAM: one synchronous write port with byte enables, one registered read port with a valid strobe, configurable width and depth. After reset or on request, a built-in sweep clears every word to zero, so cache tag and data arrays start in a known state. Sits inside the cache as the storage primitive for tag, valid and data arrays.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  pulse: restart the zeroing sweep from address 0.
- busy  out  1  high while the sweep runs; port requests are ignored.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle strobe: rdata holds the result of the read issued in the previous cycle.

## Operation
- States: CLEAR, RUN. reset_n low forces CLEAR with sweep counter = 0. Reset outputs: busy=1, rvalid=0, rdata=0.
- CLEAR: each cycle writes all-zero to mem[cnt], then cnt++. After writing DEPTH-1, the block moves to RUN. The sweep takes exactly DEPTH cycles. we, re and wbe are ignored. rvalid=0 and rdata holds its value.
- RUN: busy=0.
  - Write: when we=1, for each i with wbe[i]=1, byte i of mem[waddr] <= byte i of wdata. Other bytes are unchanged. we=1 with wbe=0 is a no-op.
  - Read: when re=1, rdata <= mem[raddr] and rvalid <= 1 on the next edge. When re=0, rvalid <= 0 and rdata holds its value.
- clr=1 in any state: next state CLEAR, cnt=0, busy=1 from the next cycle. A write or read in the same cycle as clr is dropped. A clr during a sweep restarts it from 0.
- Reset mid-sweep: the sweep restarts from 0. Memory contents are undefined until the sweep completes; the memory array has no reset.
- Read-during-write to the same address: behaviour is set by the configuration macro below.
- Different read and write addresses in the same cycle are fully independent.

## Timing
- Read latency: 1 cycle. A request at edge N produces rdata and rvalid=1 after edge N+1.
- Write: effective at the edge where it is sampled. A read of the same address issued in the next cycle returns the new data.
- busy is a registered output. It rises the cycle after clr, or immediately on reset assertion. It falls the cycle after the write to address DEPTH-1.
- Back-to-back reads, one per cycle, with no bubbles. rvalid stays high continuously.

## Configuration
- DPRAM_BYPASS_EN defined: write-first. A same-cycle read of waddr returns the merged word: enabled bytes from wdata, the other bytes from the old contents.
- Not defined: read-first. The same-cycle read returns the old contents. This maps directly onto vendor block RAM.

## Structure
- Shared package dpram_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN);
  - the localparam function for byte count (DATA_W/8);
  - the byte-merge function used for writes and for the bypass path.
- One sub-module, dpram_clr_seq: the sweep counter and state machine. It outputs busy, the sweep address and the sweep write strobe. The top-level multiplexes the sweep onto the write port.
- The memory array stays inline in the top-level so synthesis infers block RAM.

## Test plan
(DATA_W=32, ADDR_W=5)
- Reset release -> busy=1 for exactly 32 cycles, then 0. Reading addresses 0..31 returns 0x00000000 with rvalid=1 one cycle after each re.
- Write 0xDEADBEEF to addr 3 with wbe=0xF. Then write 0x11223344 to addr 3 with wbe=0x5 -> read of addr 3 returns 0xDE22BE44.
- Same-cycle write 0xCAFEF00D (wbe=0xF) and read of addr 7 (old 0x0) -> rdata=0xCAFEF00D with DPRAM_BYPASS_EN, 0x00000000 without it. A read in the next cycle returns 0xCAFEF00D in both builds.
- clr pulse after filling addr 31 with 0xFFFFFFFF -> busy high for 32 cycles. A write issued during busy to addr 5 is dropped. Afterwards addr 5 and addr 31 read 0x00000000.
- reset_n asserted at sweep count 10 -> busy, rdata and rvalid go to reset values immediately. After release the sweep runs a full 32 cycles.
- re held high for 8 cycles over addresses 0..7 -> rvalid high for 8 consecutive cycles with a 1-cycle offset and the correct data each cycle.
